// File: rtl/iahbl_sram_ctrl.sv
// ---------------------------------------------------------------------------
// iahbl_sram_ctrl
//
// AHB-Lite slave that terminates the instruction-side bus of the CPU
// subsystem and maps the IAHBL region (base 0x0000_0000) onto a single-port
// synchronous SRAM with a one-cycle read latency.
//
// The slave decodes transfer size and byte lanes. It inserts a configurable
// number of data-phase wait states. Illegal accesses get the two-cycle AHB
// ERROR response and never reach the SRAM.
//
// Parameters
//   MEM_AW       SRAM word-address width (2^MEM_AW x 32-bit words).
//                Must be 29 or less so that an out-of-range field exists.
//   WAIT_STATES  extra data-phase wait cycles per transfer, 0..3
//
// Ports
//   cpu_clk            in   sole clock, rising edge
//   sys_rst            in   synchronous active-high reset
//   iahbl_pad_htrans   in   AHB htrans, only bit[1] is decoded
//   iahbl_pad_haddr    in   byte address
//   iahbl_pad_hsize    in   0=byte, 1=half, 2=word
//   iahbl_pad_hwrite   in   1=write
//   iahbl_pad_hwdata   in   write data, valid during the data phase
//   pad_iahbl_hrdata   out  read data, zero outside the read-data cycle
//   pad_iahbl_hready   out  transfer done / bus ready
//   pad_iahbl_hresp    out  1=ERROR
//   sram_cs            out  SRAM access strobe
//   sram_we            out  SRAM write enable
//   sram_addr          out  SRAM word address
//   sram_wmask         out  byte-lane write enables, bit n = bits[8n+7:8n]
//   sram_wdata         out  SRAM write data
//   sram_rdata         in   SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module iahbl_sram_ctrl #(
    parameter int MEM_AW      = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic              cpu_clk,
    input  logic              sys_rst,
    input  logic [1:0]        iahbl_pad_htrans,
    input  logic [31:0]       iahbl_pad_haddr,
    input  logic [2:0]        iahbl_pad_hsize,
    input  logic              iahbl_pad_hwrite,
    input  logic [31:0]       iahbl_pad_hwdata,
    output logic [31:0]       pad_iahbl_hrdata,
    output logic              pad_iahbl_hready,
    output logic              pad_iahbl_hresp,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [3:0]        sram_wmask,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        WAIT,
        RDATA,
        ERR1,
        ERR2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [MEM_AW-1:0] addr_q;
    logic              write_q;
    logic [3:0]        mask_q;
    logic [1:0]        wait_cnt;

    logic              capture;
    logic              illegal;
    logic [3:0]        lane_mask;

    logic              hready_c;
    logic              hresp_c;
    logic [31:0]       hrdata_c;
    logic              cs_c;
    logic              we_c;
    logic [3:0]        wmask_c;

    // htrans[0] only separates NONSEQ from SEQ and IDLE from BUSY.
    // Neither difference matters to this slave.
    logic              unused_htrans;
    assign unused_htrans = iahbl_pad_htrans[0];

    // A transfer is accepted on any cycle where the master presents a valid
    // transfer and this slave is ready. The pipelined next address
    // is taken in the same cycle that the previous data phase completes.
    assign capture = iahbl_pad_htrans[1] & hready_c;

    // Illegal transfers are decoded from the live address-phase signals.
    // The decision is folded straight into the next state (ACC or ERR1),
    // so it is never stored.
    always_comb begin
        illegal = 1'b0;
        if (iahbl_pad_hsize > 3'd2) begin
            illegal = 1'b1;
        end
        if ((iahbl_pad_hsize == 3'd1) && iahbl_pad_haddr[0]) begin
            illegal = 1'b1;
        end
        if ((iahbl_pad_hsize == 3'd2) && (iahbl_pad_haddr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
        if (iahbl_pad_haddr[31:MEM_AW+2] != '0) begin
            illegal = 1'b1;
        end
    end

    // Little-endian byte-lane decode. Word, and any oversize request,
    // enables all lanes. Oversize requests are errored and never written.
    always_comb begin
        lane_mask = 4'b1111;
        case (iahbl_pad_hsize)
            3'd0:    lane_mask = 4'b0001 << iahbl_pad_haddr[1:0];
            3'd1:    lane_mask = 4'b0011 << {iahbl_pad_haddr[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    end

    // State register plus the address-phase capture registers.
    // The wait counter is loaded while in ACC. It counts down through WAIT,
    // so the last wait cycle is the one where the counter reads 1.
    always_ff @(posedge cpu_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            mask_q   <= 4'b0000;
            wait_cnt <= 2'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q  <= iahbl_pad_haddr[MEM_AW+1:2];
                write_q <= iahbl_pad_hwrite;
                mask_q  <= lane_mask;
            end
            if (state == ACC) begin
                wait_cnt <= 2'(WAIT_STATES);
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    // Next-state and bus/SRAM outputs.
    // Every state that drives hready high ends a data phase. Such a state
    // then either takes the pending address phase or falls back to IDLE.
    // That common decision is made once, after the per-state case.
    always_comb begin
        state_next = state;
        hready_c   = 1'b1;
        hresp_c    = 1'b0;
        hrdata_c   = 32'h0000_0000;
        cs_c       = 1'b0;
        we_c       = 1'b0;
        wmask_c    = 4'b0000;

        unique case (state)
            IDLE: begin
                hready_c = 1'b1;
            end

            ACC: begin
                cs_c    = 1'b1;
                we_c    = write_q;
                wmask_c = mask_q & {4{write_q}};
                // A write without wait states is done as soon as the SRAM
                // takes it. Reads always need the extra RDATA cycle.
                if (write_q && (WAIT_STATES == 0)) begin
                    hready_c = 1'b1;
                end else begin
                    hready_c   = 1'b0;
                    state_next = (WAIT_STATES > 0) ? WAIT : RDATA;
                end
            end

            WAIT: begin
                hready_c = 1'b0;
                if (wait_cnt == 2'd1) begin
                    if (write_q) begin
                        hready_c = 1'b1;
                    end else begin
                        // Re-issue the read so the SRAM output is fresh
                        // in RDATA regardless of how long we waited.
                        cs_c       = 1'b1;
                        we_c       = 1'b0;
                        state_next = RDATA;
                    end
                end
            end

            RDATA: begin
                hready_c = 1'b1;
                hrdata_c = sram_rdata;
            end

            ERR1: begin
                hready_c   = 1'b0;
                hresp_c    = 1'b1;
                state_next = ERR2;
            end

            ERR2: begin
                hready_c = 1'b1;
                hresp_c  = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (hready_c) begin
            if (iahbl_pad_htrans[1]) begin
                state_next = illegal ? ERR1 : ACC;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Bus outputs come straight from the decode above.
    assign pad_iahbl_hready = hready_c;
    assign pad_iahbl_hresp  = hresp_c;
    assign pad_iahbl_hrdata = hrdata_c;

    // A reset that lands while in ACC aborts the transfer. The strobes are
    // suppressed in that cycle so the SRAM never sees a half-aborted write.
    assign sram_cs    = cs_c & ~sys_rst;
    assign sram_we    = we_c & ~sys_rst;
    assign sram_wmask = wmask_c & {4{~sys_rst}};
    assign sram_addr  = addr_q;
    assign sram_wdata = iahbl_pad_hwdata;

endmodule

// File: tb/tb_iahbl_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iahbl_sram_ctrl
//
// Drives two controller instances, one with no wait states and one with
// two, through a pipelined AHB-Lite master. Each instance has its own
// behavioural SRAM. Expected bus responses come from a word-level memory
// model that derives latency, error, lane and data behaviour from the bus
// rules.
// ---------------------------------------------------------------------------
module tb_iahbl_sram_ctrl;

    localparam int MEM_AW = 14;

    typedef struct packed {
        logic        idle;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic                   cpu_clk = 1'b0;
    logic                   sys_rst;

    logic [1:0][1:0]        htrans;
    logic [1:0][31:0]       haddr;
    logic [1:0][2:0]        hsize;
    logic [1:0]             hwrite;
    logic [1:0][31:0]       hwdata;
    logic [1:0][31:0]       hrdata;
    logic [1:0]             hready;
    logic [1:0]             hresp;
    logic [1:0]             sram_cs;
    logic [1:0]             sram_we;
    logic [1:0][MEM_AW-1:0] sram_addr;
    logic [1:0][3:0]        sram_wmask;
    logic [1:0][31:0]       sram_wdata;

    int          checks = 0;
    int          errors = 0;
    xfer_t       pending[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_read;

    always #5 cpu_clk = ~cpu_clk;

    // Unit 0 runs without wait states and unit 1 with two.
    // Each unit has a simple SRAM that honours the write mask and returns
    // read data one cycle after the strobe.
    for (genvar g = 0; g < 2; g++) begin : unit
        logic [31:0] mem [int];
        logic [31:0] rdata_q;
        logic [31:0] merged;

        iahbl_sram_ctrl #(
            .MEM_AW      (MEM_AW),
            .WAIT_STATES (g == 0 ? 0 : 2)
        ) dut (
            .cpu_clk          (cpu_clk),
            .sys_rst          (sys_rst),
            .iahbl_pad_htrans (htrans[g]),
            .iahbl_pad_haddr  (haddr[g]),
            .iahbl_pad_hsize  (hsize[g]),
            .iahbl_pad_hwrite (hwrite[g]),
            .iahbl_pad_hwdata (hwdata[g]),
            .pad_iahbl_hrdata (hrdata[g]),
            .pad_iahbl_hready (hready[g]),
            .pad_iahbl_hresp  (hresp[g]),
            .sram_cs          (sram_cs[g]),
            .sram_we          (sram_we[g]),
            .sram_addr        (sram_addr[g]),
            .sram_wmask       (sram_wmask[g]),
            .sram_wdata       (sram_wdata[g]),
            .sram_rdata       (rdata_q)
        );

        always @(posedge cpu_clk) begin
            if (sram_cs[g]) begin
                if (sram_we[g]) begin
                    merged = mem.exists(int'(sram_addr[g])) ? mem[int'(sram_addr[g])] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (sram_wmask[g][b]) merged[8*b +: 8] = sram_wdata[g][8*b +: 8];
                    end
                    mem[int'(sram_addr[g])] = merged;
                end else begin
                    rdata_q <= mem.exists(int'(sram_addr[g])) ? mem[int'(sram_addr[g])] : 32'h0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int waitOf(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    // Bus legality straight from the rules: size fits a word, the address
    // is a multiple of the transfer size, and the address is inside the SRAM.
    function automatic logic isIllegal(input xfer_t x);
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0) return 1'b1;
        if (x.addr >= (32'd1 << (MEM_AW + 2))) return 1'b1;
        return 1'b0;
    endfunction

    // The bytes touched by a transfer are offset .. offset+nbytes-1.
    function automatic logic [3:0] laneMask(input xfer_t x);
        logic [3:0] m;
        int lo;
        int n;
        m  = 4'b0000;
        lo = int'(x.addr[1:0]);
        n  = 1 << int'(x.size);
        for (int b = 0; b < 4; b++) begin
            if ((b >= lo) && (b < lo + n)) m[b] = 1'b1;
        end
        return m;
    endfunction

    // The SRAM is strobed on the first data-phase cycle of any legal access.
    // A read is strobed again one cycle before its data is returned.
    function automatic logic expCs(input logic err, input logic wr, input int cyc, input int lat, input int w);
        if (err) return 1'b0;
        if (wr) return cyc == 1;
        return (cyc == 1) || ((w > 0) && (cyc == lat - 1));
    endfunction

    task automatic applyStimulus(input int u, input logic valid, input xfer_t x);
        if (valid && !x.idle) begin
            htrans[u] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            haddr[u]  = x.addr;
            hsize[u]  = x.size;
            hwrite[u] = x.write;
        end else begin
            htrans[u] = 2'($urandom_range(0, 1));
            haddr[u]  = $urandom();
            hsize[u]  = 3'($urandom_range(0, 7));
            hwrite[u] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pushXfer(input logic wr, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.idle  = 1'b0;
        x.write = wr;
        x.size  = size;
        x.addr  = addr;
        x.wdata = wdata;
        pending.push_back(x);
    endtask

    task automatic genRandom(input int n);
        xfer_t x;
        int word;
        int lo;
        for (int i = 0; i < n; i++) begin
            x.idle  = ($urandom_range(0, 9) == 0);
            x.write = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            word    = $urandom_range(0, 31);
            lo      = $urandom_range(0, 3);
            if ((x.size <= 3'd2) && ($urandom_range(0, 6) != 0)) lo = lo & ~((1 << int'(x.size)) - 1);
            x.addr  = 32'(word * 4 + lo);
            if ($urandom_range(0, 19) == 0) x.addr = x.addr | (32'd1 << $urandom_range(MEM_AW + 2, 31));
            x.wdata = $urandom();
            pending.push_back(x);
        end
    endtask

    // Pipelined master that runs everything in the pending queue on one
    // unit. It is entered and left just after a rising edge, with the
    // unit idle.
    task automatic runQueue(input int u);
        xfer_t       dp;
        xfer_t       ap;
        logic        dp_valid;
        logic        ap_valid;
        logic        hr;
        logic        err;
        int          cyc;
        int          lat;
        int          stall;
        int          key;
        int          w;
        logic [3:0]  exp_mask;
        logic [31:0] exp_read;
        logic [31:0] merged;
        dp = '0; ap = '0; dp_valid = 1'b0; ap_valid = 1'b0; err = 1'b0;
        cyc = 0; lat = 0; stall = 0; key = 0; exp_mask = 4'b0000;
        w = waitOf(u);
        if (pending.size() > 0) begin
            ap = pending.pop_front();
            ap_valid = 1'b1;
        end
        applyStimulus(u, ap_valid, ap);
        while (dp_valid || ap_valid) begin
            @(negedge cpu_clk);
            hr = hready[u];
            if (dp_valid) begin
                cyc++;
                key = u * 65536 + int'(dp.addr[MEM_AW+1:2]);
                checkOutput("hready", {31'd0, hr}, {31'd0, cyc == lat});
                checkOutput("hresp", {31'd0, hresp[u]}, {31'd0, err});
                checkOutput("sram_cs", {31'd0, sram_cs[u]}, {31'd0, expCs(err, dp.write, cyc, lat, w)});
                if ((cyc == 1) && !err) begin
                    checkOutput("sram_we", {31'd0, sram_we[u]}, {31'd0, dp.write});
                    checkOutput("sram_addr", 32'(sram_addr[u]), 32'(dp.addr[MEM_AW+1:2]));
                    checkOutput("sram_wmask", {28'd0, sram_wmask[u]}, {28'd0, dp.write ? exp_mask : 4'b0000});
                    if (dp.write) checkOutput("sram_wdata", sram_wdata[u], dp.wdata);
                end
                exp_read = 32'h0;
                if (hr && !err && !dp.write) exp_read = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                checkOutput("hrdata", hrdata[u], exp_read);
                if (hr) begin
                    if (!err && dp.write) begin
                        merged = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (exp_mask[b]) merged[8*b +: 8] = dp.wdata[8*b +: 8];
                        end
                        ref_mem[key] = merged;
                    end
                    if (!dp.write) last_read = hrdata[u];
                    dp_valid = 1'b0;
                end
            end else begin
                checkOutput("idle_hready", {31'd0, hr}, 32'd1);
                checkOutput("idle_hresp", {31'd0, hresp[u]}, 32'd0);
            end
            stall = hr ? 0 : stall + 1;
            if (stall > 20) begin
                checkOutput("hready_timeout", stall, 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "[TB] bus stuck with hready low");
            end
            @(posedge cpu_clk);
            #1;
            if (hr && ap_valid) begin
                if (!ap.idle) begin
                    dp       = ap;
                    dp_valid = 1'b1;
                    cyc      = 0;
                    err      = isIllegal(ap);
                    lat      = err ? 2 : (ap.write ? 1 + w : 2 + w);
                    exp_mask = laneMask(ap);
                end
                ap_valid = 1'b0;
                if (pending.size() > 0) begin
                    ap = pending.pop_front();
                    ap_valid = 1'b1;
                end
            end
            applyStimulus(u, ap_valid, ap);
            hwdata[u] = (dp_valid && dp.write) ? dp.wdata : $urandom();
        end
        htrans[u] = 2'b00;
    endtask

    // Reset lands in the ACC cycle of a word write. The SRAM must not be
    // strobed, and the slave must come back idle and ready.
    task automatic resetDuringWrite(input int u, input logic [31:0] addr);
        htrans[u] = 2'b10;
        haddr[u]  = addr;
        hsize[u]  = 3'd2;
        hwrite[u] = 1'b1;
        @(posedge cpu_clk);
        #1;
        htrans[u] = 2'b00;
        hwdata[u] = 32'hFFFF_0000;
        sys_rst   = 1'b1;
        @(negedge cpu_clk);
        checkOutput("rst_cycle_cs", {31'd0, sram_cs[u]}, 32'd0);
        checkOutput("rst_cycle_we", {31'd0, sram_we[u]}, 32'd0);
        @(posedge cpu_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge cpu_clk);
        checkOutput("post_rst_hready", {31'd0, hready[u]}, 32'd1);
        checkOutput("post_rst_cs", {31'd0, sram_cs[u]}, 32'd0);
        checkOutput("post_rst_hresp", {31'd0, hresp[u]}, 32'd0);
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sys_rst   = 1'b1;
        last_read = 32'h0;
        for (int u = 0; u < 2; u++) begin
            htrans[u] = 2'b00;
            haddr[u]  = 32'h0;
            hsize[u]  = 3'd0;
            hwrite[u] = 1'b0;
            hwdata[u] = 32'h0;
        end
        repeat (3) @(posedge cpu_clk);
        #1;
        @(negedge cpu_clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput("reset_hready", {31'd0, hready[u]}, 32'd1);
            checkOutput("reset_hresp", {31'd0, hresp[u]}, 32'd0);
            checkOutput("reset_hrdata", hrdata[u], 32'd0);
            checkOutput("reset_cs", {31'd0, sram_cs[u]}, 32'd0);
            checkOutput("reset_we", {31'd0, sram_we[u]}, 32'd0);
            checkOutput("reset_wmask", {28'd0, sram_wmask[u]}, 32'd0);
        end
        @(posedge cpu_clk);
        #1;
        sys_rst = 1'b0;
        $display("[TB] reset released");

        // Word write then readback with no wait states.
        pushXfer(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        pushXfer(1'b0, 3'd2, 32'h0000_0100, 32'h0);
        runQueue(0);
        checkOutput("raw_readback", last_read, 32'hDEAD_BEEF);

        // Byte-lane merge into a preloaded word.
        pushXfer(1'b1, 3'd2, 32'h0000_0200, 32'h1122_3344);
        pushXfer(1'b1, 3'd0, 32'h0000_0203, 32'hAA00_0000);
        pushXfer(1'b0, 3'd2, 32'h0000_0200, 32'h0);
        runQueue(0);
        checkOutput("byte_merge", last_read, 32'hAA22_3344);

        // Misaligned half, out-of-range word, oversize transfer.
        pushXfer(1'b0, 3'd1, 32'h0000_0101, 32'h0);
        pushXfer(1'b0, 3'd2, 32'h0001_0000, 32'h0);
        pushXfer(1'b1, 3'd2, 32'h0001_0000, 32'h1234_5678);
        pushXfer(1'b1, 3'd3, 32'h0000_0000, 32'h1234_5678);
        pushXfer(1'b0, 3'd2, 32'h0000_0000, 32'h0);
        runQueue(0);

        // Back-to-back read/read/write with two wait states.
        pushXfer(1'b1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D);
        pushXfer(1'b0, 3'd2, 32'h0000_0040, 32'h0);
        pushXfer(1'b0, 3'd2, 32'h0000_0044, 32'h0);
        pushXfer(1'b1, 3'd1, 32'h0000_0046, 32'h5555_0000);
        pushXfer(1'b0, 3'd2, 32'h0000_0044, 32'h0);
        runQueue(1);
        checkOutput("ws_half_merge", last_read, 32'h5555_0000);

        // Reset in the ACC cycle of a write, on both units.
        for (int u = 0; u < 2; u++) begin
            pushXfer(1'b1, 3'd2, 32'h0000_0300, 32'h5A5A_1234);
            runQueue(u);
            resetDuringWrite(u, 32'h0000_0300);
            pushXfer(1'b0, 3'd2, 32'h0000_0300, 32'h0);
            runQueue(u);
            checkOutput("rst_word_unchanged", last_read, 32'h5A5A_1234);
        end

        // Randomised traffic on both units.
        for (int u = 0; u < 2; u++) begin
            genRandom(200);
            runQueue(u);
            $display("[TB] random traffic done on unit %0d", u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
